hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 48 ++++
 rtl/hazard_ctrl_md_busy_ctr.sv | 38 +++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for hazard control:
// forward select encodings, scoreboard slot type and helper functions.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MD_LAT_DEFAULT = 32;
  localparam int CNT_W          = 6;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
    logic       memtoreg;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '{
    valid:    1'b0,
    dst:      5'd0,
    regwrite: 1'b0,
    memtoreg: 1'b0
  };

  // r0 is hard-wired zero, so a slot targeting it never produces a value
  function automatic logic is_writer(
    input sb_slot_t s
  );
    return s.valid & s.regwrite & (s.dst != 5'd0);
  endfunction

  // Memory-stage producer is younger, so it wins over Writeback
  function automatic logic [1:0] fwd_sel(
    input sb_slot_t   m,
    input sb_slot_t   w,
    input logic [4:0] r
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (is_writer(m) && (m.dst == r))
      sel = FWD_MEM;
    else if (is_writer(w) && (w.dst == r))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Multiply/divide busy counter: start loads MD_LAT-1, then counts down.
// Ports: clk, clr (async, active-high), start_i (issue), busy_o (count!=0).
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic start_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // a new issue restarts the count even while busy
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = RELOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: E/M/W destination scoreboard, stall/flush and
// operand forwarding selects; mdbusy comes from md_busy_ctr.
// Ports: Decode/Execute register numbers and controls in; stalls,
// flushes, forward selects and mdbusy out. clr is async active-high.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] rsd,
  input  logic [4:0] rtd,
  input  logic [4:0] rse,
  input  logic [4:0] rte,
  input  logic [4:0] writeregd,
  input  logic       regwrited,
  input  logic       memtoregd,
  input  logic       branchd,
  input  logic       pcsrcd,
  input  logic       mfhilod,
  input  logic       mdstarte,
  output logic       stallf,
  output logic       stalld,
  output logic       flushe,
  output logic       flushd,
  output logic [1:0] forwardae,
  output logic [1:0] forwardbe,
  output logic       forwardad,
  output logic       forwardbd,
  output logic       mdbusy
);

  sb_slot_t e_q, m_q, w_q;
  sb_slot_t e_d;

  logic e_wr, m_wr;
  logic e_hit, m_hit;
  logic lwstall;
  logic branchstall;
  logic mdstall;
  logic stall;

  // a Writeback slot is only a forward source; its load flag is dead
  logic unused_w_memtoreg;
  assign unused_w_memtoreg = w_q.memtoreg;

  always_comb begin
    e_d = SLOT_EMPTY;
    if (!stall) begin
      e_d.valid    = 1'b1;
      e_d.dst      = writeregd;
      e_d.regwrite = regwrited;
      e_d.memtoreg = memtoregd;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      e_q <= SLOT_EMPTY;
      m_q <= SLOT_EMPTY;
      w_q <= SLOT_EMPTY;
    end else begin
      e_q <= e_d;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  md_busy_ctr #(
    .MD_LAT (MD_LAT)
  ) u_md (
    .clk     (clk),
    .clr     (clr),
    .start_i (mdstarte),
    .busy_o  (mdbusy)
  );

  assign e_wr  = is_writer(e_q);
  assign m_wr  = is_writer(m_q);
  assign e_hit = (e_q.dst == rsd) | (e_q.dst == rtd);
  assign m_hit = (m_q.dst == rsd) | (m_q.dst == rtd);

  assign lwstall = e_wr & e_q.memtoreg & e_hit;

  // Decode compares need the value now: any E producer, or an M load
  assign branchstall = branchd &
    ((e_wr & e_hit) | (m_wr & m_q.memtoreg & m_hit));

  assign mdstall = mfhilod & mdbusy;

  assign stall  = lwstall | branchstall | mdstall;
  assign stallf = stall;
  assign stalld = stall;
  assign flushe = stall;

  // a stalled branch keeps its slot and resolves again afterwards
  assign flushd = pcsrcd & ~stall;

  assign forwardae = fwd_sel(m_q, w_q, rse);
  assign forwardbe = fwd_sel(m_q, w_q, rte);

  assign forwardad = m_wr & ~m_q.memtoreg & (m_q.dst == rsd);
  assign forwardbd = m_wr & ~m_q.memtoreg & (m_q.dst == rtd);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand
// sequences for multiply/divide and reset, then random vs a model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int LAT = 4;
  localparam int NV  = 14;
  localparam int NR  = 600;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] rsd, rtd, rse, rte, writeregd;
  logic       regwrited, memtoregd, branchd, pcsrcd;
  logic       mfhilod, mdstarte;
  logic       stallf, stalld, flushe, flushd;
  logic [1:0] forwardae, forwardbe;
  logic       forwardad, forwardbd, mdbusy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(LAT)) dut (
    .clk       (clk),
    .clr       (clr),
    .rsd       (rsd),
    .rtd       (rtd),
    .rse       (rse),
    .rte       (rte),
    .writeregd (writeregd),
    .regwrited (regwrited),
    .memtoregd (memtoregd),
    .branchd   (branchd),
    .pcsrcd    (pcsrcd),
    .mfhilod   (mfhilod),
    .mdstarte  (mdstarte),
    .stallf    (stallf),
    .stalld    (stalld),
    .flushe    (flushe),
    .flushd    (flushd),
    .forwardae (forwardae),
    .forwardbe (forwardbe),
    .forwardad (forwardad),
    .forwardbd (forwardbd),
    .mdbusy    (mdbusy)
  );

  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wr;
    logic rw, mt, br, pc, mf, ms;
  } stim_t;

  typedef struct packed {
    logic       stall, fld;
    logic [1:0] fae, fbe;
    logic       fad, fbd, busy;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(
    input int a, b, c, d, w,
    input bit rw, mt, br, pc, mf, ms,
    input bit st, fl, input int fa, fb,
    input bit ad, bd, bz
  );
    vec_t v;
    v.s.rsd = 5'(a); v.s.rtd = 5'(b);
    v.s.rse = 5'(c); v.s.rte = 5'(d);
    v.s.wr = 5'(w);
    v.s.rw = rw; v.s.mt = mt; v.s.br = br;
    v.s.pc = pc; v.s.mf = mf; v.s.ms = ms;
    v.e.stall = st; v.e.fld = fl;
    v.e.fae = 2'(fa); v.e.fbe = 2'(fb);
    v.e.fad = ad; v.e.fbd = bd; v.e.busy = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_out(input string t, input exp_t e);
    chk({t, ".stalld"},    int'(stalld),    int'(e.stall));
    chk({t, ".stallf"},    int'(stallf),    int'(e.stall));
    chk({t, ".flushe"},    int'(flushe),    int'(e.stall));
    chk({t, ".flushd"},    int'(flushd),    int'(e.fld));
    chk({t, ".forwardae"}, int'(forwardae), int'(e.fae));
    chk({t, ".forwardbe"}, int'(forwardbe), int'(e.fbe));
    chk({t, ".forwardad"}, int'(forwardad), int'(e.fad));
    chk({t, ".forwardbd"}, int'(forwardbd), int'(e.fbd));
    chk({t, ".mdbusy"},    int'(mdbusy),    int'(e.busy));
  endtask

  task automatic apply(input stim_t s);
    rsd = s.rsd; rtd = s.rtd; rse = s.rse; rte = s.rte;
    writeregd = s.wr; regwrited = s.rw; memtoregd = s.mt;
    branchd = s.br; pcsrcd = s.pc; mfhilod = s.mf;
    mdstarte = s.ms;
  endtask

  task automatic idle();
    apply('0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    idle();
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  // ---------------- behavioural reference ----------------
  // Instructions are remembered by age: [0] one cycle old (Execute),
  // [1] two cycles (Memory), [2] three cycles (Writeback).
  typedef struct {
    bit v;
    int dst;
    bit rw;
    bit mt;
  } rec_t;

  rec_t hist[$];
  int   edges  = 0;
  int   md_end = 0;

  function automatic bit writes(input rec_t r);
    return r.v && r.rw && r.dst != 0;
  endfunction

  function automatic bit uses(input rec_t r, input int a, input int b);
    return r.dst == a || r.dst == b;
  endfunction

  function automatic int fwd(input rec_t m, input rec_t w, input int r);
    if (writes(m) && m.dst == r) return 2;
    if (writes(w) && w.dst == r) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    rec_t z;
    z = '{0, 0, 0, 0};
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back(z);
    md_end = 0;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    rec_t ex, mm, wb;
    bit lw, bs, busy;
    int a, b;
    ex = hist[0]; mm = hist[1]; wb = hist[2];
    a = int'(rsd); b = int'(rtd);
    lw = writes(ex) && ex.mt && uses(ex, a, b);
    bs = branchd && ((writes(ex) && uses(ex, a, b)) ||
                     (writes(mm) && mm.mt && uses(mm, a, b)));
    busy = edges < md_end;
    e.stall = lw || bs || (mfhilod && busy);
    e.fld   = pcsrcd && !e.stall;
    e.fae   = 2'(fwd(mm, wb, int'(rse)));
    e.fbe   = 2'(fwd(mm, wb, int'(rte)));
    e.fad   = writes(mm) && !mm.mt && mm.dst == a;
    e.fbd   = writes(mm) && !mm.mt && mm.dst == b;
    e.busy  = busy;
    return e;
  endfunction

  task automatic model_clock();
    exp_t e;
    rec_t n;
    e = model_exp();
    edges++;
    if (clr) return;
    if (e.stall) n = '{0, 0, 0, 0};
    else n = '{1, int'(writeregd), regwrited, memtoregd};
    hist.push_front(n);
    void'(hist.pop_back());
    if (mdstarte) md_end = edges + LAT - 1;
  endtask

  // ---------------- test ----------------
  initial begin
    exp_t e;
    stim_t s;
    clr = 1'b1;
    idle();

    // reset state; flushd still follows pcsrcd
    pcsrcd = 1'b1;
    #2;
    e = '0; e.fld = 1'b1;
    check_out("reset", e);
    @(posedge clk);
    #1 clr = 1'b0;
    idle();

    //           rsd rtd rse rte wr rw mt br pc mf ms | st fl fa fb ad bd bz
    tbl[0]  = mk(1, 2, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(8, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(8, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 8, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 9, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 5, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 5, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);
    tbl[7]  = mk(0, 0, 5, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(3, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 3, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 4, 0, 4, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].s);
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].e);
      @(posedge clk);
      #1;
    end

    // multiply/divide: busy for LAT-1 cycles, mfhi stalls meanwhile
    do_reset();
    mdstarte = 1'b1;
    #1 chk("md.pre_busy", int'(mdbusy), 0);
    @(posedge clk);
    #1 mdstarte = 1'b0;
    mfhilod = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      #1;
      chk($sformatf("md.busy%0d", k), int'(mdbusy), int'(k < LAT - 1));
      chk($sformatf("md.stall%0d", k), int'(stalld), int'(k < LAT - 1));
      @(posedge clk);
      #1;
    end

    // restart while busy reloads the full count
    mfhilod = 1'b0;
    mdstarte = 1'b1;
    @(posedge clk);
    #1 mdstarte = 1'b0;
    @(posedge clk);
    #1 mdstarte = 1'b1;
    @(posedge clk);
    #1 mdstarte = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      #1;
      chk($sformatf("md.restart%0d", k), int'(mdbusy), int'(k < LAT - 1));
      @(posedge clk);
      #1;
    end

    // reset mid-operation: everything drops without a clock edge
    do_reset();
    s = '0; s.wr = 5'd8; s.rw = 1'b1; s.mt = 1'b1; s.ms = 1'b1;
    apply(s);
    @(posedge clk);
    #1 s.ms = 1'b0;
    apply(s);
    @(posedge clk);
    #1 idle();
    rsd = 5'd8; rse = 5'd8; mfhilod = 1'b1; pcsrcd = 1'b1;
    #1;
    e = '0; e.stall = 1'b1; e.fae = FWD_MEM; e.busy = 1'b1;
    check_out("pre_clr", e);
    #1 clr = 1'b1;
    #1;
    e = '0; e.fld = 1'b1;
    check_out("async_clr", e);
    @(posedge clk);
    #1 check_out("held_clr", e);
    clr = 1'b0;
    #1 check_out("post_clr", e);

    // random traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < NR; i++) begin
      rsd = 5'($urandom_range(0, 7));
      rtd = 5'($urandom_range(0, 7));
      rse = 5'($urandom_range(0, 7));
      rte = 5'($urandom_range(0, 7));
      writeregd = 5'($urandom_range(0, 7));
      regwrited = ($urandom_range(0, 3) != 0);
      memtoregd = ($urandom_range(0, 2) == 0);
      branchd   = ($urandom_range(0, 3) == 0);
      pcsrcd    = ($urandom_range(0, 3) == 0);
      mfhilod   = ($urandom_range(0, 2) == 0);
      mdstarte  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1;
        model_reset();
      end
      #1;
      check_out($sformatf("rnd%0d", i), model_exp());
      @(posedge clk);
      model_clock();
      #1 clr = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
